// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t    : fetch FSM states (REQ may issue, WAIT one request
//                      outstanding, DROP outstanding response is discarded)
//   NOP_INSTR        : instruction shown on instr_o when the buffer is empty
//   DEFAULT_RESET_PC : default first fetch address after reset
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs between the memory response path and
// the decode stage. Entry 0 is always the head; a pop shifts entry 1 down.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   push_i, push_pc_i,
//   push_instr_i           : write a new entry at the tail
//   pop_i                  : drop the head entry
//   flush_i                : empty the buffer (wins over push/pop)
//   count_o                : number of valid entries (0..2)
//   head_pc_o, head_instr_o: head entry contents (meaningful when count_o!=0)
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o
);

    logic [DATA_W-1:0] pc_q    [2];
    logic [DATA_W-1:0] instr_q [2];
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    // Guard against pushing into a full buffer or popping an empty one.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    pc_q[count_q[0]]    <= push_pc_i;
                    instr_q[count_q[0]] <= push_instr_i;
                    count_q             <= count_q + 2'd1;
                end
                2'b01: begin
                    pc_q[0]    <= pc_q[1];
                    instr_q[0] <= instr_q[1];
                    count_q    <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; new entry lands behind the survivor.
                    if (count_q == 2'd1) begin
                        pc_q[0]    <= push_pc_i;
                        instr_q[0] <= push_instr_i;
                    end else begin
                        pc_q[0]    <= pc_q[1];
                        instr_q[0] <= instr_q[1];
                        pc_q[1]    <= push_pc_i;
                        instr_q[1] <= push_instr_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = pc_q[0];
    assign head_instr_o = instr_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time to the
// instruction memory, buffers up to two responses with their addresses, and
// handles redirects from control by flushing and discarding in-flight data.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   PCsrc_i              : redirect pulse, branch_target_i is the new PC
//   imem_req_o/addr_o    : request to instruction memory
//   imem_gnt_i           : request accepted this cycle
//   imem_rvalid_i/rdata_i: response for the outstanding request
//   instr_o, pc_o        : buffer head (NOP and fetch_pc when empty)
//   instr_valid_o        : buffer non-empty
//   instr_ready_i        : downstream consumes the head
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    // Buffer is a fixed 2-entry FIFO; only 2 is supported.
    parameter int                     BUF_DEPTH     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     PCsrc_i,
    input  logic [ADDRESS_WIDTH-1:0] branch_target_i,
    output logic                     imem_req_o,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [ADDRESS_WIDTH-1:0] imem_rdata_i,
    output logic [ADDRESS_WIDTH-1:0] instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
    logic [ADDRESS_WIDTH-1:0] tag_q;
    logic [1:0]               buf_count;
    logic [ADDRESS_WIDTH-1:0] head_pc;
    logic [ADDRESS_WIDTH-1:0] head_instr;
    logic                     granted;
    logic                     push;
    logic                     pop;
    logic                     unused_target_lo;

    // Redirect targets are forced word aligned, so the low bits never matter.
    assign unused_target_lo = ^branch_target_i[1:0];

    // Request gating: rst_ni keeps the bus quiet during reset cycles, and a
    // redirect suppresses the request so no fetch to the old path is issued.
    assign imem_req_o  = rst_ni && (state_q == REQ) &&
                         (buf_count < 2'(BUF_DEPTH)) && !PCsrc_i;
    assign imem_addr_o = {fetch_pc_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign granted     = imem_req_o && imem_gnt_i;

    // Redirect overrides push and pop; the buffer is flushed instead.
    assign push = (state_q == WAIT) && imem_rvalid_i && !PCsrc_i;
    assign pop  = instr_valid_o && instr_ready_i && !PCsrc_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     if (granted) state_d = WAIT;
            WAIT:    if (imem_rvalid_i) state_d = REQ;
                     else if (PCsrc_i)  state_d = DROP;
            DROP:    if (imem_rvalid_i) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= REQ;
            fetch_pc_q <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
            tag_q      <= '0;
        end else begin
            state_q <= state_d;
            if (PCsrc_i) begin
                fetch_pc_q <= {branch_target_i[ADDRESS_WIDTH-1:2], 2'b00};
            end else if (granted) begin
                fetch_pc_q <= fetch_pc_q + ADDRESS_WIDTH'(4);
                tag_q      <= imem_addr_o;
            end
        end
    end

    fetch_buffer #(
        .DATA_W (ADDRESS_WIDTH)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_pc_i    (tag_q),
        .push_instr_i (imem_rdata_i),
        .pop_i        (pop),
        .flush_i      (PCsrc_i),
        .count_o      (buf_count),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    assign instr_valid_o = (buf_count != 2'd0);
    assign instr_o       = instr_valid_o ? head_instr : ADDRESS_WIDTH'(NOP_INSTR);
    assign pc_o          = instr_valid_o ? head_pc    : fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, back-pressure, redirect
// in WAIT with and without a coincident response, address wrap, and reset
// with a late response in flight.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        PCsrc_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .PCsrc_i         (PCsrc_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; PCsrc_i = 1'b0; branch_target_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        instr_ready_i = 1'b0;

        // ---- reset ----
        #1;
        chk("req_in_reset", 32'(imem_req_o), 32'd0);
        tick(); tick();
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);

        // ---- sequential fetch 0x0, 0x4, 0x8 ----
        rst_ni = 1'b1; imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        #1;
        chk("seq_req0", 32'(imem_req_o), 32'd1);
        chk("seq_addr0", imem_addr_o, 32'h0);
        tick();                                   // grant 0x0 -> WAIT
        chk("seq_wait_noreq", 32'(imem_req_o), 32'd0);
        chk("seq_wait_empty", 32'(instr_valid_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0001;
        tick();                                   // push I0
        imem_rvalid_i = 1'b0;
        chk("seq_valid0", 32'(instr_valid_o), 32'd1);
        chk("seq_instr0", instr_o, 32'hAAAA_0001);
        chk("seq_pc0", pc_o, 32'h0);
        chk("seq_addr1", imem_addr_o, 32'h4);
        tick();                                   // grant 0x4, pop I0
        chk("seq_empty_pc", pc_o, 32'h8);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0002;
        tick();                                   // push I1
        imem_rvalid_i = 1'b0;
        chk("seq_instr1", instr_o, 32'hAAAA_0002);
        chk("seq_pc1", pc_o, 32'h4);
        chk("seq_addr2", imem_addr_o, 32'h8);
        tick();                                   // grant 0x8, pop I1
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0003;
        tick();                                   // push I2
        imem_rvalid_i = 1'b0;
        chk("seq_instr2", instr_o, 32'hAAAA_0003);
        chk("seq_pc2", pc_o, 32'h8);

        // ---- back-pressure: buffer fills to 2, requests stop ----
        instr_ready_i = 1'b0;
        #1;
        chk("bp_addr", imem_addr_o, 32'hC);
        tick();                                   // grant 0xC
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0004;
        tick();                                   // push I3 -> count 2
        imem_rvalid_i = 1'b0;
        chk("bp_count2", 32'(dut.buf_count), 32'd2);
        chk("bp_noreq", 32'(imem_req_o), 32'd0);
        tick();
        chk("bp_still_noreq", 32'(imem_req_o), 32'd0);
        chk("bp_head_held", instr_o, 32'hAAAA_0003);
        instr_ready_i = 1'b1;
        #1;
        chk("bp_noreq_same_cycle", 32'(imem_req_o), 32'd0);
        tick();                                   // pop I2
        chk("bp_resume_req", 32'(imem_req_o), 32'd1);
        chk("bp_resume_addr", imem_addr_o, 32'h10);
        chk("bp_head_next", pc_o, 32'hC);

        // ---- redirect in WAIT without response -> DROP ----
        tick();                                   // grant 0x10, pop I3
        PCsrc_i = 1'b1; branch_target_i = 32'h0000_0103;
        tick();                                   // WAIT -> DROP
        PCsrc_i = 1'b0;
        chk("rd_state_drop", 32'(dut.state_q), 32'(DROP));
        chk("rd_empty", 32'(instr_valid_o), 32'd0);
        chk("rd_drop_noreq", 32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();                                   // discard
        imem_rvalid_i = 1'b0;
        chk("rd_discard_valid", 32'(instr_valid_o), 32'd0);
        chk("rd_discard_instr", instr_o, 32'h0000_0013);
        chk("rd_target_addr", imem_addr_o, 32'h0000_0100);
        chk("rd_target_req", 32'(imem_req_o), 32'd1);

        // ---- redirect and response together in WAIT ----
        tick();                                   // grant 0x100
        PCsrc_i = 1'b1; branch_target_i = 32'h0000_0200;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
        tick();
        PCsrc_i = 1'b0; imem_rvalid_i = 1'b0;
        chk("rv_empty", 32'(instr_valid_o), 32'd0);
        chk("rv_state_req", 32'(dut.state_q), 32'(REQ));
        chk("rv_target_addr", imem_addr_o, 32'h0000_0200);

        // ---- address wrap from 0xFFFF_FFFC ----
        PCsrc_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
        #1;
        chk("wr_pcsrc_blocks_req", 32'(imem_req_o), 32'd0);
        tick();                                   // redirect in REQ
        PCsrc_i = 1'b0;
        #1;
        chk("wr_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        tick();                                   // grant 0xFFFF_FFFC
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0005;
        tick();
        imem_rvalid_i = 1'b0;
        chk("wr_pc_top", pc_o, 32'hFFFF_FFFC);
        chk("wr_addr_wrap", imem_addr_o, 32'h0);

        // ---- reset in WAIT, late response ignored ----
        tick();                                   // grant 0x0, pop I5 -> WAIT
        rst_ni = 1'b0; imem_gnt_i = 1'b0;
        #1;
        chk("rs_req_in_reset", 32'(imem_req_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        chk("rs_pc", pc_o, 32'h0);
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1A7E_1A7E;
        tick();                                   // late response, REQ ignores
        imem_rvalid_i = 1'b0;
        chk("rs_late_valid", 32'(instr_valid_o), 32'd0);
        chk("rs_late_instr", instr_o, 32'h0000_0013);
        imem_gnt_i = 1'b1;
        tick();                                   // grant RESET_PC
        chk("rs_wait_valid", 32'(instr_valid_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0006;
        tick();
        imem_rvalid_i = 1'b0;
        chk("rs_fill_valid", 32'(instr_valid_o), 32'd1);
        chk("rs_fill_instr", instr_o, 32'hAAAA_0006);
        chk("rs_fill_pc", pc_o, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, sets the width of the address and instruction buses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 2, is the instruction buffer depth; only the value 2 is supported.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 PCsrc_i  in  1  redirect request from control; one-cycle pulse.
REQ-007 branch_target_i  in  ADDRESS_WIDTH  redirect address, sampled when PCsrc_i=1.
REQ-008 imem_req_o  out  1  instruction memory request.
REQ-009 imem_addr_o  out  ADDRESS_WIDTH  request address, word aligned.
REQ-010 imem_gnt_i  in  1  memory accepts the request this cycle.
REQ-011 imem_rvalid_i  in  1  read data valid, one or more cycles after the grant.
REQ-012 imem_rdata_i  in  ADDRESS_WIDTH  instruction word.
REQ-013 instr_o  out  ADDRESS_WIDTH  buffer head instruction, fed to control instr_i.
REQ-014 pc_o  out  ADDRESS_WIDTH  address of instr_o.
REQ-015 instr_valid_o  out  1  buffer non-empty.
REQ-016 instr_ready_i  in  1  downstream consumes the head when instr_valid_o=1.

Function
REQ-017 States: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to discard).
REQ-018 At most one request is outstanding at any time.
REQ-019 In REQ, imem_req_o=1 when registered count<BUF_DEPTH and PCsrc_i=0; otherwise imem_req_o=0.
REQ-020 imem_addr_o equals fetch_pc with bits[1:0]=0.
REQ-021 REQ with req&gnt: go to WAIT, latch the request address as tag, and set fetch_pc to fetch_pc+4, wrapping modulo 2^ADDRESS_WIDTH.
REQ-022 WAIT with rvalid: push {tag, imem_rdata_i} into the buffer and go to REQ.
REQ-023 DROP with rvalid: discard the data, push nothing, and go to REQ.
REQ-024 rvalid_i in REQ is ignored.
REQ-025 PCsrc_i=1 has priority over all other events. It flushes the buffer (count=0 next cycle) and sets fetch_pc to {branch_target_i[31:2],2'b00}.
REQ-026 On redirect the state transitions are: REQ goes to REQ; WAIT without rvalid goes to DROP; WAIT with rvalid goes to REQ, discarding the data; DROP with rvalid goes to REQ; DROP without rvalid stays in DROP.
REQ-027 A pop occurs when instr_valid_o&instr_ready_i. Push and pop in the same cycle leave count unchanged. Redirect overrides both.
REQ-028 Empty buffer: instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=fetch_pc.
REQ-029 The first instruction becomes visible on instr_o the cycle after its rvalid, giving one-cycle fill latency.
REQ-030 Outputs depend on registered state only, except imem_req_o, which also depends on PCsrc_i.

Reset
REQ-031 While rst_ni=0 at the clock edge: state=REQ, fetch_pc=RESET_PC, count=0, and outstanding is cleared.
REQ-032 Post-reset outputs: imem_req_o=0 during reset cycles, instr_valid_o=0, instr_o=NOP, pc_o=RESET_PC.
REQ-033 Reset mid-WAIT or mid-DROP abandons the outstanding response; a late rvalid after reset is ignored per REQ-024.

Structure
REQ-034 Shared package fetch_pkg holds the state enum fetch_state_t {REQ, WAIT, DROP}, NOP_INSTR=32'h0000_0013, and the default RESET_PC.
REQ-035 One sub-module, fetch_buffer: a 2-entry FIFO of {pc, instr} with push, pop, flush, count, and head outputs.

Verification
REQ-036 Reset, then gnt=1, rvalid one cycle after grant, ready=1 -> imem_addr_o sequence 0x0, 0x4, 0x8; pc_o/instr_o follow in order, each one cycle after its rvalid.
REQ-037 ready=0 with an always-granting memory -> exactly 2 grants, then imem_req_o=0 and count=2; raising ready resumes requests the next cycle.
REQ-038 PCsrc_i=1, target 0x0000_0103, in WAIT -> state DROP; the following rvalid data never appears; next imem_addr_o=0x0000_0100.
REQ-039 PCsrc_i and rvalid in the same cycle in WAIT -> data discarded, buffer empty, next request addresses the target.
REQ-040 fetch_pc=0xFFFF_FFFC granted -> next imem_addr_o=0x0000_0000.
REQ-041 rst_ni=0 asserted in WAIT, rvalid arrives 2 cycles after reset release -> ignored; instr_valid_o stays 0 until the RESET_PC response arrives.
